add_share_arbiter: RTL and testbench
====================================

ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, 0, requester holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-006 req0_a / req1_a, req0_b / req1_b  input  64  operands A, B.
REQ-007 req0_chain / req1_chain  input  1  use requester's stored carry as Cin (multi-word add).
REQ-008 req0_sub / req1_sub  input  1  subtract, A-B (present only with ADD_SHARE_SUB_EN).
REQ-009 res_valid  output  1  result register holds a result.
REQ-010 res_ready  input  1  consumer takes the result this cycle.
REQ-011 res_sum  output  64  result sum.
REQ-012 res_cout  output  1  carry out of bit 63.
REQ-013 res_id  output  1  index of the requester that owns the result.

Function
REQ-014 One shared 64-bit Brent-Kung parallel-prefix adder instance; Sum/Cout identical to (A + B' + Cin) mod 2^65 split.
REQ-015 FSM states: IDLE (empty), CALC (operand register loaded), OUT (result register valid).
REQ-016 Accept window: state IDLE, or state OUT with res_ready=1.
REQ-017 Grant: combinational; with one valid requester it wins; with both valid, the requester holding the priority pointer wins.
REQ-018 reqN_ready=1 only for the granted requester inside the accept window; never both high.
REQ-019 Transfer = reqN_valid & reqN_ready; on transfer: capture A, B', Cin, id into operand register; state -> CALC; priority pointer -> the other requester.
REQ-020 Pointer unchanged on cycles without a transfer.
REQ-021 Cin = chain ? stored carry[id] : (sub ? 1 : 0); B' = sub ? ~B : B; without the macro sub is treated as 0.
REQ-022 CALC -> OUT unconditionally next edge; result register loads sum, cout, id; carry[id] <= cout.
REQ-023 Latency: transfer at edge N -> res_valid=1 after edge N+1; back-to-back throughput one op per 2 cycles.
REQ-024 OUT with res_ready=1 and no transfer -> IDLE, res_valid=0; OUT with res_ready=0 -> hold all result outputs stable.
REQ-025 OUT with res_ready=1 and a transfer the same cycle -> CALC (result drained, new op captured).
REQ-026 Stored carry of the non-owning requester is never modified.
REQ-027 chain=1 on a requester's first op after reset uses carry 0.
REQ-028 reqN_valid may drop without transfer; no state change results.

Reset
REQ-029 rst_n=0 asynchronously forces: state IDLE, res_valid 0, res_sum 0, res_cout 0, res_id 0, carry[0..1] 0, pointer PRIO_INIT, operand register 0.
REQ-030 Reset during CALC or OUT discards the in-flight operation; no result is presented after release.
REQ-031 First transfer possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro ADD_SHARE_SUB_EN defined: req0_sub/req1_sub ports exist; sub=1 inverts B; Cin=1 unless chain=1.
REQ-033 Macro ADD_SHARE_SUB_EN undefined: sub ports absent, B never inverted, Cin = chain ? carry[id] : 0.

Verification
REQ-034 req0: A=0xFFFF_FFFF_FFFF_FFFF, B=1, chain=0 -> 2 cycles later res_sum=0, res_cout=1, res_id=0.
REQ-035 req0 then chained req0 (A=0, B=0, chain=1) -> res_sum=1, res_cout=0 (128-bit carry propagates); an intervening req1 op leaves carry[0] untouched.
REQ-036 Both valid continuously, PRIO_INIT=0 -> grant order 0,1,0,1; never both ready high.
REQ-037 res_ready=0 for 5 cycles in OUT -> res_* stable, reqN_ready=0 throughout; res_ready=1 with req1 valid -> drain and accept same cycle.
REQ-038 rst_n pulsed low mid-CALC -> res_valid=0 immediately and after release; carries read 0.
REQ-039 With ADD_SHARE_SUB_EN: A=5, B=7, sub=1 -> res_sum=0xFFFF_FFFF_FFFF_FFFE, res_cout=0; A=7, B=5 -> res_sum=2, res_cout=1.

Source files
------------

// File: rtl/add_share_arbiter.sv
// Two-requester arbiter sharing one 64-bit Brent-Kung adder with per-requester carry chaining.
// Optional subtract support is enabled by defining ADD_SHARE_SUB_EN.

module add_share_bk64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_cin,
    output logic [63:0] o_sum,
    output logic        o_cout
);

    // Up-sweep builds prefixes at 2^k-1 nodes, down-sweep fills the rest.
    function automatic logic [64:0] bk_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin);
        logic [63:0] p0;
        logic [63:0] g;
        logic [63:0] p;
        logic [64:0] c;
        logic [63:0] s;
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        for (int d = 1; d < 64; d = d * 2) begin
            for (int i = 2 * d - 1; i < 64; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        for (int d = 16; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 64; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        c[0] = cin;
        for (int i = 0; i < 64; i++) begin
            c[i+1] = g[i] | (p[i] & cin);
            s[i]   = p0[i] ^ c[i];
        end
        return {c[64], s};
    endfunction

    assign {o_cout, o_sum} = bk_add(i_a, i_b, i_cin);

endmodule

module add_share_arbiter #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_chain,
`ifdef ADD_SHARE_SUB_EN
    input  logic        req0_sub,
    input  logic        req1_sub,
`endif
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_chain,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_sum,
    output logic        res_cout,
    output logic        res_id
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        id;
    } op_t;

    state_t      r_state;
    state_t      w_state_nxt;
    op_t         r_op;
    logic        r_ptr;
    logic [1:0]  r_carry;
    logic [63:0] r_sum;
    logic        r_cout;
    logic        r_id;

    logic        w_win;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_xfer;
    logic        w_sel;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_bx;
    logic        w_chain;
    logic        w_sub;
    logic        w_cin;
    logic [63:0] w_sum;
    logic        w_cout;

    // Pointer names the requester that wins when both are valid.
    assign w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);
    assign w_gnt1 = req1_valid & (~req0_valid |  r_ptr);

    assign req0_ready = w_win & w_gnt0;
    assign req1_ready = w_win & w_gnt1;
    assign w_xfer     = req0_ready | req1_ready;
    assign w_sel      = req1_ready;

    assign w_a     = w_sel ? req1_a     : req0_a;
    assign w_b     = w_sel ? req1_b     : req0_b;
    assign w_chain = w_sel ? req1_chain : req0_chain;
`ifdef ADD_SHARE_SUB_EN
    assign w_sub   = w_sel ? req1_sub   : req0_sub;
`else
    assign w_sub   = 1'b0;
`endif
    assign w_bx  = w_sub ? ~w_b : w_b;
    assign w_cin = w_chain ? r_carry[w_sel] : w_sub;

    add_share_bk64 u_add (
        .i_a    (r_op.a),
        .i_b    (r_op.b),
        .i_cin  (r_op.cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_win       = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_win = 1'b1;
                if (w_xfer) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                w_win     = res_ready;
                if (res_ready) w_state_nxt = w_xfer ? S_CALC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_ptr   <= PRIO_INIT;
            r_carry <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_op  <= '{a: w_a, b: w_bx, cin: w_cin, id: w_sel};
                r_ptr <= ~w_sel;
            end
            // Only the owner's carry is refreshed; the other requester's chain stays intact.
            if (r_state == S_CALC) begin
                r_sum            <= w_sum;
                r_cout           <= w_cout;
                r_id             <= r_op.id;
                r_carry[r_op.id] <= w_cout;
            end
        end
    end

    assign res_sum  = r_sum;
    assign res_cout = r_cout;
    assign res_id   = r_id;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: vector table plus arbitration, stall and reset sequences.
`timescale 1ns/1ps
module tb_add_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_chain = 1'b0, req1_chain = 1'b0;
`ifdef ADD_SHARE_SUB_EN
    logic        req0_sub = 1'b0, req1_sub = 1'b0;
`endif
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_sum;
    logic        res_cout;
    logic        res_id;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    add_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_chain (req0_chain),
`ifdef ADD_SHARE_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_chain (req1_chain),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic ch);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_chain = ch;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_chain = ch;
        end
    endtask

    // One full transaction: request, latency check, result check, drain.
    task automatic do_op(input string nm, input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic ch, input logic [63:0] es, input logic ec);
        int n;
        n = 0;
        @(negedge clk);
        drive(id, 1'b1, a, b, ch);
        #2;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        chk({nm, "_accept"}, 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        drive(id, 1'b0, a, b, ch);
        @(negedge clk);
        chk({nm, "_calc_valid"}, 64'(res_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(res_valid), 64'd1);
        chk({nm, "_sum"},   res_sum, es);
        chk({nm, "_cout"},  64'(res_cout), 64'(ec));
        chk({nm, "_id"},    64'(res_id), 64'(id));
        res_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_drained"}, 64'(res_valid), 64'd0);
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic        chain;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] grants;
        int         ng;
        logic       both_hi;

        vecs[0] = '{1'b0, ONES, 64'd1, 1'b0, 64'd0, 1'b1};
        vecs[1] = '{1'b1, 64'd3, 64'd4, 1'b0, 64'd7, 1'b0};
        vecs[2] = '{1'b0, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0};
        vecs[3] = '{1'b1, MSB, MSB, 1'b0, 64'd0, 1'b1};
        vecs[4] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1,
                    64'h1234_5678_9ABC_DF01, 1'b0};
        vecs[5] = '{1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, ONES, 1'b0};
        vecs[6] = '{1'b0, ONES, ONES, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[7] = '{1'b0, ONES, 64'd0, 1'b1, 64'd0, 1'b1};

        // Reset state
        #3;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum",   res_sum, 64'd0);
        chk("rst_cout",  64'(res_cout), 64'd0);
        chk("rst_id",    64'(res_id), 64'd0);
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters continuously valid: alternate starting with 0
        grants  = '0;
        ng      = 0;
        both_hi = 1'b0;
        res_ready = 1'b1;
        drive(1'b0, 1'b1, 64'd1, 64'd2, 1'b0);
        drive(1'b1, 1'b1, 64'd3, 64'd4, 1'b0);
        for (int k = 0; k < 30 && ng < 4; k++) begin
            #2;
            if (req0_ready && req1_ready) both_hi = 1'b1;
            if (req0_ready || req1_ready) begin
                grants[ng] = req1_ready;
                ng++;
            end
            if (ng < 4) @(negedge clk);
        end
        chk("arb_count", 64'(ng), 64'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("arb_grant%0d", k), 64'(grants[k]), 64'(k % 2));
        chk("arb_both_ready", 64'(both_hi), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("arb_idle", 64'(res_valid), 64'd0);
        res_ready = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].chain,
                  vecs[i].sum, vecs[i].cout);

        // Stall in OUT for 5 cycles, then drain and accept req1 on the same edge
        @(negedge clk);
        drive(1'b0, 1'b1, ONES, 64'd1, 1'b0);
        #2;
        chk("stall_acc0", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, MSB, MSB, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("stall%0d_valid", k), 64'(res_valid), 64'd1);
            chk($sformatf("stall%0d_sum", k),   res_sum, 64'd0);
            chk($sformatf("stall%0d_cout", k),  64'(res_cout), 64'd1);
            chk($sformatf("stall%0d_id", k),    64'(res_id), 64'd0);
            chk($sformatf("stall%0d_ready", k), 64'({req0_ready, req1_ready}), 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #2;
        chk("stall_drain_acc1", 64'(req1_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        res_ready = 1'b0;
        @(negedge clk);
        chk("stall_calc_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        chk("stall_r1_valid", 64'(res_valid), 64'd1);
        chk("stall_r1_sum",   res_sum, 64'd0);
        chk("stall_r1_cout",  64'(res_cout), 64'd1);
        chk("stall_r1_id",    64'(res_id), 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset pulsed while an op sits in CALC; both carries were 1 beforehand
        @(negedge clk);
        drive(1'b1, 1'b1, 64'd5, 64'd6, 1'b0);
        #2;
        chk("rstc_acc", 64'(req1_ready), 64'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstc_valid_now", 64'(res_valid), 64'd0);
        chk("rstc_cout_now",  64'(res_cout), 64'd0);
        chk("rstc_id_now",    64'(res_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstc_valid_after%0d", k), 64'(res_valid), 64'd0);
        end
        do_op("rstc_carry0", 1'b0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0);
        do_op("rstc_carry1", 1'b1, 64'd1, 64'd1, 1'b1, 64'd2, 1'b0);

`ifdef ADD_SHARE_SUB_EN
        req0_sub = 1'b1;
        do_op("sub_5m7", 1'b0, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        do_op("sub_7m5", 1'b0, 64'd7, 64'd5, 1'b0, 64'd2, 1'b1);
        req0_sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
